alu_op_issuer: RTL and testbench
================================

Name: alu_op_issuer

Overview:
Command-side initiator for the 16-bit combinational ALU.
- Accepts operation requests over a valid/ready handshake and drives the ALU operand/select buses.
- Waits a fixed settle time, captures result and carry, and returns them over a second valid/ready handshake.
- Traps divide-by-zero locally and keeps a completed-operation counter. Sits between a sequencer/CPU datapath and the ALU instance.

Parameters:
WIDTH, 16, operand/result width
SEL_W, 4, ALU select width
SETTLE_CYCLES, 1, clock edges between driving the ALU buses and sampling the result; legal range 1..15, elaboration-time error otherwise
CNT_W, 16, width of op_count

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset; asserting it (0) clears all state immediately
cmd_valid  in  1  request valid
cmd_ready  out  1  issuer can accept a request
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
cmd_sel  in  SEL_W  ALU opcode (ALU encoding, 0000 ADD … 1111 EQ)
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_sel  out  SEL_W  to ALU select
alu_result  in  WIDTH  from ALU output
alu_carry  in  1  from ALU CarryOut (always carry of A+B, for any opcode)
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_data  out  WIDTH  captured result
rsp_carry  out  1  captured carry
rsp_err  out  1  1 = divide by zero, op not issued
op_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, async)
  - State goes to IDLE.
  - alu_a, alu_b, alu_sel, rsp_data, rsp_carry, rsp_err, rsp_valid, op_count and the settle counter are all 0.
  - cmd_ready = 0 while reset is asserted, otherwise (state==IDLE).
- FSM states: IDLE, DRIVE, RESP.
- IDLE: cmd_ready=1. Accept on the edge with cmd_valid&&cmd_ready.
  - Normal accept (not a divide-by-zero): register cmd_a/b/sel onto alu_a/b/sel, load settle counter with SETTLE_CYCLES, go to DRIVE.
  - Divide-by-zero: cmd_sel==OP_DIV (0011) and cmd_b==0.
    - alu_* are not updated.
    - rsp_data=all-ones, rsp_carry=0, rsp_err=1.
    - Go straight to RESP; rsp_valid is high 1 edge after accept.
- DRIVE: cmd_ready=0; the counter decrements each edge.
  - On the edge where counter==1: rsp_data<=alu_result, rsp_carry<=alu_carry, rsp_err<=0, go to RESP.
  - rsp_valid is therefore high exactly SETTLE_CYCLES edges after the accept edge.
- RESP: rsp_valid=1; rsp_data/carry/err held stable; cmd_ready=0, and cmd_valid is ignored.
  - On rsp_valid&&rsp_ready: op_count+1 (wrapping), rsp_valid<=0, go to IDLE.
  - The error response also counts.
- alu_a/b/sel hold their last issued values after completion; they never return to 0 except on reset.
- No overlap: at most one op in flight. Minimum throughput is SETTLE_CYCLES+2 cycles per op, with rsp_ready tied high.
- Reset mid-DRIVE or mid-RESP: the op is dropped with no response, all outputs clear immediately, op_count is 0.
- Arithmetic: the block does no arithmetic on data apart from the divide-by-zero check; the result is passed through unmodified.

Decomposition:
- Shared package alu_pkg:
  - WIDTH/SEL_W defaults.
  - Opcode constants OP_ADD=0000 … OP_DIV=0011 … OP_GT=1110, OP_EQ=1111.
  - FSM state enum.
- The same package is used by the ALU and the bench.
- No sub-module needed: the settle counter and FSM fit in one module.
- The bench instantiates the issuer plus the ALU, connected back-to-back.

Test Plan:
1. Reset release, SETTLE_CYCLES=1, ADD A=0x0003 B=0x0004, rsp_ready=1 -> alu_a=0x0003 one edge after accept; rsp_valid one edge later; rsp_data=0x0007, rsp_carry=0, rsp_err=0; op_count=1.
2. ADD A=0xFFFF B=0x0001 -> rsp_data=0x0000, rsp_carry=1, rsp_err=0.
3. DIV A=0x0010 B=0x0000 -> rsp_valid 1 edge after accept; rsp_data=0xFFFF, rsp_err=1; alu_a/b/sel unchanged from the previous op; op_count increments.
4. XOR A=0x00FF B=0x0F0F with rsp_ready low for 5 cycles while cmd_valid stays high -> rsp_data=0x0FF0 stable throughout; cmd_ready=0; second command accepted only after the response handshake.
5. SETTLE_CYCLES=3 build, SUB A=0x0005 B=0x0007 -> rsp_valid rises exactly 3 edges after the accept edge; rsp_data=0xFFFE.
6. Assert reset asynchronously mid-DRIVE, between edges -> all outputs 0 before the next edge; after release, cmd_ready=1 and no stale response appears.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU, its command-side issuer and the bench:
// bus widths, opcode encoding and the issuer state enum.
package alu_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEL_W = 4;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP
    } issuer_state_e;

endpackage

// File: rtl/alu_op_issuer_if.sv
// Command and response handshakes between a sequencer (master) and the
// ALU operation issuer (slave).
interface alu_op_issuer_if #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [SEL_W-1:0] cmd_sel;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_carry;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
    );
endinterface

// File: rtl/alu.sv
// Combinational 16-function ALU; carry is always the carry-out of a+b,
// whatever the selected operation.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign carry = sum[WIDTH];

    always_comb begin
        result = '0;
        case (sel)
            OP_ADD:  result = sum[WIDTH-1:0];
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_DIV:  result = (b == '0) ? '1 : a / b;
            OP_SHL:  result = a << 1;
            OP_SHR:  result = a >> 1;
            OP_ROL:  result = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROR:  result = {a[0], a[WIDTH-1:1]};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_NAND: result = ~(a & b);
            OP_XNOR: result = ~(a ^ b);
            OP_GT:   result = (a > b) ? WIDTH'(1) : '0;
            OP_EQ:   result = (a == b) ? WIDTH'(1) : '0;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues one ALU operation at a time: drives the ALU buses, waits a fixed
// settle time, then returns the captured result; divide-by-zero is trapped here.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SEL_W         = DEF_SEL_W,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               reset,
    alu_op_issuer_if.slave     bus,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [SEL_W-1:0]   alu_sel,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carry,
    output logic [CNT_W-1:0]   op_count
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("alu_op_issuer: SETTLE_CYCLES must be within 1..15");
    end

    issuer_state_e    state;
    issuer_state_e    state_next;
    logic [3:0]       settle_cnt;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_carry;
    logic             rsp_err;
    logic             accept;
    logic             div_zero;

    // cmd_ready is gated by reset so nothing looks acceptable while held in reset
    assign bus.cmd_ready = reset && (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_carry = rsp_carry;
    assign bus.rsp_err   = rsp_err;

    assign accept   = bus.cmd_valid && bus.cmd_ready;
    assign div_zero = (bus.cmd_sel == SEL_W'(OP_DIV)) && (bus.cmd_b == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = div_zero ? RESP : DRIVE;
            DRIVE:   if (settle_cnt == 4'd1) state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A trapped divide never touches the ALU buses, so they keep the last issued op
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            settle_cnt <= '0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (div_zero) begin
                            rsp_data  <= '1;
                            rsp_carry <= 1'b0;
                            rsp_err   <= 1'b1;
                        end else begin
                            alu_a      <= bus.cmd_a;
                            alu_b      <= bus.cmd_b;
                            alu_sel    <= bus.cmd_sel;
                            settle_cnt <= 4'(SETTLE_CYCLES);
                        end
                    end
                end
                DRIVE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt == 4'd1) begin
                        rsp_data  <= alu_result;
                        rsp_carry <= alu_carry;
                        rsp_err   <= 1'b0;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) op_count <= op_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Drives two issuer+ALU pairs (settle 1 and settle 3) with random and directed
// operations and compares every response against an arithmetic reference model.
module tb_alu_op_issuer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int which;
    int checks_total;
    int checks_passed;

    logic        tb_valid;
    logic        tb_rsp_ready;
    logic [15:0] tb_a;
    logic [15:0] tb_b;
    logic [3:0]  tb_sel;

    logic [15:0] last_a [2];
    logic [15:0] last_b [2];
    logic [3:0]  last_sel [2];
    logic [15:0] exp_count [2];

    alu_op_issuer_if #(.WIDTH(16), .SEL_W(4)) bus1 ();
    alu_op_issuer_if #(.WIDTH(16), .SEL_W(4)) bus3 ();

    logic [15:0] alu_a1, alu_b1, alu_res1, op_count1;
    logic [15:0] alu_a3, alu_b3, alu_res3, op_count3;
    logic [3:0]  alu_sel1, alu_sel3;
    logic        alu_c1, alu_c3;

    assign bus1.cmd_valid = tb_valid && (which == 0);
    assign bus1.cmd_a     = tb_a;
    assign bus1.cmd_b     = tb_b;
    assign bus1.cmd_sel   = tb_sel;
    assign bus1.rsp_ready = tb_rsp_ready && (which == 0);
    assign bus3.cmd_valid = tb_valid && (which == 1);
    assign bus3.cmd_a     = tb_a;
    assign bus3.cmd_b     = tb_b;
    assign bus3.cmd_sel   = tb_sel;
    assign bus3.rsp_ready = tb_rsp_ready && (which == 1);

    alu_op_issuer #(.WIDTH(16), .SEL_W(4), .SETTLE_CYCLES(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1),
        .alu_result(alu_res1), .alu_carry(alu_c1), .op_count(op_count1)
    );
    alu #(.WIDTH(16)) u_alu1 (
        .a(alu_a1), .b(alu_b1), .sel(alu_sel1), .result(alu_res1), .carry(alu_c1)
    );

    alu_op_issuer #(.WIDTH(16), .SEL_W(4), .SETTLE_CYCLES(3), .CNT_W(16)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3),
        .alu_result(alu_res3), .alu_carry(alu_c3), .op_count(op_count3)
    );
    alu #(.WIDTH(16)) u_alu3 (
        .a(alu_a3), .b(alu_b3), .sel(alu_sel3), .result(alu_res3), .carry(alu_c3)
    );

    logic        obs_cmd_ready, obs_rsp_valid, obs_carry, obs_err;
    logic [15:0] obs_data, obs_a, obs_b, obs_count;
    logic [3:0]  obs_sel;

    // Whichever issuer is currently selected is the one the checks look at
    always_comb begin
        obs_cmd_ready = bus1.cmd_ready;
        obs_rsp_valid = bus1.rsp_valid;
        obs_data      = bus1.rsp_data;
        obs_carry     = bus1.rsp_carry;
        obs_err       = bus1.rsp_err;
        obs_a         = alu_a1;
        obs_b         = alu_b1;
        obs_sel       = alu_sel1;
        obs_count     = op_count1;
        if (which == 1) begin
            obs_cmd_ready = bus3.cmd_ready;
            obs_rsp_valid = bus3.rsp_valid;
            obs_data      = bus3.rsp_data;
            obs_carry     = bus3.rsp_carry;
            obs_err       = bus3.rsp_err;
            obs_a         = alu_a3;
            obs_b         = alu_b3;
            obs_sel       = alu_sel3;
            obs_count     = op_count3;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] modelResult(input logic [15:0] a, input logic [15:0] b,
                                                input logic [3:0] sel);
        int unsigned ua = a;
        int unsigned ub = b;
        case (sel)
            OP_ADD:  return 16'((ua + ub) % 65536);
            OP_SUB:  return 16'((ua + 65536 - ub) % 65536);
            OP_MUL:  return 16'((ua * ub) % 65536);
            OP_DIV:  return (ub == 0) ? 16'hFFFF : 16'(ua / ub);
            OP_SHL:  return 16'((ua * 2) % 65536);
            OP_SHR:  return 16'(ua / 2);
            OP_ROL:  return 16'((ua * 2) % 65536 + ua / 32768);
            OP_ROR:  return 16'(ua / 2 + (ua % 2) * 32768);
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_NAND: return ~(a & b);
            OP_XNOR: return ~(a ^ b);
            OP_GT:   return (ua > ub) ? 16'd1 : 16'd0;
            default: return (ua == ub) ? 16'd1 : 16'd0;
        endcase
    endfunction

    task automatic resetModel();
        for (int k = 0; k < 2; k++) begin
            last_a[k]    = '0;
            last_b[k]    = '0;
            last_sel[k]  = '0;
            exp_count[k] = '0;
        end
    endtask

    // One complete operation on the selected issuer, holding the response for 'stall' cycles
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] sel, input int stall);
        logic [15:0] exp_data;
        logic        exp_carry;
        logic        exp_err;
        int          settle;
        int          n;
        int          lat;
        exp_err   = (sel == OP_DIV) && (b == 16'd0);
        exp_data  = exp_err ? 16'hFFFF : modelResult(a, b, sel);
        exp_carry = exp_err ? 1'b0 : ((32'(a) + 32'(b)) >= 32'd65536);
        settle    = (which == 0) ? 1 : 3;
        if (!exp_err) begin
            last_a[which]   = a;
            last_b[which]   = b;
            last_sel[which] = sel;
        end

        tb_a = a; tb_b = b; tb_sel = sel; tb_valid = 1'b1;
        tb_rsp_ready = (stall == 0);
        n = 0;
        while (!obs_cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("accept_wait", 32'(n < 20), 32'd1);

        @(posedge clk); #1;
        tb_valid = (stall > 0);
        tb_a = ~a; tb_b = ~b; tb_sel = ~sel;
        checkOutput("alu_a", obs_a, last_a[which]);
        checkOutput("alu_b", obs_b, last_b[which]);
        checkOutput("alu_sel", obs_sel, last_sel[which]);

        lat = 0;
        while (!obs_rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        checkOutput("rsp_latency", lat, exp_err ? 0 : settle);
        checkOutput("rsp_data", obs_data, exp_data);
        checkOutput("rsp_carry", obs_carry, exp_carry);
        checkOutput("rsp_err", obs_err, exp_err);
        checkOutput("busy_ready", obs_cmd_ready, 1'b0);

        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", obs_rsp_valid, 1'b1);
            checkOutput("hold_data", obs_data, exp_data);
            checkOutput("hold_ready", obs_cmd_ready, 1'b0);
        end

        tb_valid = 1'b0;
        tb_rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_count[which] = exp_count[which] + 16'd1;
        checkOutput("rsp_done", obs_rsp_valid, 1'b0);
        checkOutput("op_count", obs_count, exp_count[which]);
        checkOutput("idle_ready", obs_cmd_ready, 1'b1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [3:0]  rs;
        int          stale;
        checks_total = 0; checks_passed = 0; which = 0;
        tb_valid = 1'b0; tb_rsp_ready = 1'b1;
        tb_a = '0; tb_b = '0; tb_sel = '0;
        resetModel();
        reset = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cmd_ready", obs_cmd_ready, 1'b0);
        checkOutput("rst_rsp_valid", obs_rsp_valid, 1'b0);
        checkOutput("rst_op_count", obs_count, 16'd0);
        checkOutput("rst_alu_a", obs_a, 16'd0);
        checkOutput("rst_rsp_data", obs_data, 16'd0);
        reset = 1'b1;
        #1;
        checkOutput("rel_cmd_ready", obs_cmd_ready, 1'b1);

        applyStimulus(16'h0003, 16'h0004, OP_ADD, 0);
        applyStimulus(16'hFFFF, 16'h0001, OP_ADD, 0);
        applyStimulus(16'h0010, 16'h0000, OP_DIV, 0);
        applyStimulus(16'h00FF, 16'h0F0F, OP_XOR, 5);

        for (int i = 0; i < 24; i++) begin
            rs = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            applyStimulus(ra, rb, rs, int'($urandom_range(0, 3)));
        end

        which = 1;
        applyStimulus(16'h0005, 16'h0007, OP_SUB, 0);
        applyStimulus(16'h1234, 16'h0000, OP_DIV, 2);
        for (int i = 0; i < 8; i++) begin
            rs = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            applyStimulus(ra, rb, rs, int'($urandom_range(0, 2)));
        end

        // Reset lands between edges while the settle-3 issuer is mid-DRIVE
        tb_a = 16'h0101; tb_b = 16'h0202; tb_sel = OP_OR; tb_valid = 1'b1;
        @(posedge clk); #1;
        tb_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        resetModel();
        checkOutput("async_rsp_valid", obs_rsp_valid, 1'b0);
        checkOutput("async_cmd_ready", obs_cmd_ready, 1'b0);
        checkOutput("async_alu_a", obs_a, 16'd0);
        checkOutput("async_alu_b", obs_b, 16'd0);
        checkOutput("async_alu_sel", obs_sel, 4'd0);
        checkOutput("async_rsp_data", obs_data, 16'd0);
        checkOutput("async_op_count", obs_count, 16'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checkOutput("post_rst_ready", obs_cmd_ready, 1'b1);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (obs_rsp_valid) stale++;
        end
        checkOutput("no_stale_rsp", stale, 0);
        applyStimulus(16'h8000, 16'h8000, OP_ADD, 1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
